// File: rtl/rc4_key_search_scheduler.sv
// rc4_key_search_scheduler: hands interleaved RC4 keys to parallel crack cores, stops on the first hit
// Ports: clk/reset (async, active-high); go starts a search when not busy;
// core_rst/core_start/core_key drive each core; core_done/core_hit come back from each core;
// core_abort broadcasts stop; busy/found/failed/found_key/found_core/keys_tried report status.
module rc4_key_search_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX = 24'h3FFFFF,
    localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           go,
    output logic [NUM_CORES-1:0]           core_rst,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_hit,
    output logic                           core_abort,
    output logic                           busy,
    output logic                           found,
    output logic                           failed,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [CW-1:0]                  found_core,
    output logic [KEY_WIDTH:0]             keys_tried
);
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_FOUND, S_FAILED} state_t;
    typedef enum logic [2:0] {C_IDLE, C_RST, C_START, C_RUN, C_EXH} slot_t;
    localparam logic [KEY_WIDTH:0] STEP = (KEY_WIDTH+1)'(NUM_CORES);
    localparam logic [KEY_WIDTH:0] ONE = 1;
    state_t state, state_n;
    slot_t slot [NUM_CORES];
    slot_t slot_n [NUM_CORES];
    logic [KEY_WIDTH-1:0] key [NUM_CORES];
    logic [KEY_WIDTH-1:0] key_n [NUM_CORES];
    logic found_n, failed_n, abort_n, hit_any, all_exh;
    logic [KEY_WIDTH-1:0] found_key_n;
    logic [CW-1:0] found_core_n;
    logic [KEY_WIDTH:0] tried_n;
    always_comb begin
        state_n = state;
        slot_n = slot;
        key_n = key;
        found_n = found;
        failed_n = failed;
        abort_n = core_abort;
        found_key_n = found_key;
        found_core_n = found_core;
        tried_n = keys_tried;
        hit_any = 1'b0;
        all_exh = 1'b1;
        if (state != S_SEARCH) begin
            if (go) begin
                state_n = S_SEARCH;
                found_n = 1'b0;
                failed_n = 1'b0;
                abort_n = 1'b0;
                tried_n = '0;
                for (int c = 0; c < NUM_CORES; c++) begin
                    key_n[c] = KEY_WIDTH'(c);
                    slot_n[c] = C_RST;
                end
            end
        end else begin
            // ascending scan so the lowest-index hit wins a simultaneous tie
            for (int c = 0; c < NUM_CORES; c++) begin
                if (slot[c] == C_RST)
                    slot_n[c] = key[c] > KEY_MAX ? C_EXH : C_START;
                else if (slot[c] == C_START)
                    slot_n[c] = C_RUN;
                else if (slot[c] == C_RUN && core_done[c]) begin
                    tried_n = tried_n + ONE;
                    if (core_hit[c]) begin
                        if (!hit_any) begin
                            found_key_n = key[c];
                            found_core_n = CW'(c);
                        end
                        hit_any = 1'b1;
                    end else if ({1'b0, key[c]} + STEP > {1'b0, KEY_MAX})
                        slot_n[c] = C_EXH;
                    else begin
                        key_n[c] = key[c] + KEY_WIDTH'(NUM_CORES);
                        slot_n[c] = C_RST;
                    end
                end
                all_exh = all_exh && slot_n[c] == C_EXH;
            end
            if (hit_any || all_exh) begin
                state_n = hit_any ? S_FOUND : S_FAILED;
                found_n = hit_any;
                failed_n = !hit_any;
                abort_n = 1'b1;
                for (int c = 0; c < NUM_CORES; c++) slot_n[c] = C_IDLE;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            for (int c = 0; c < NUM_CORES; c++) begin
                slot[c] <= C_IDLE;
                key[c] <= '0;
            end
            found <= 1'b0;
            failed <= 1'b0;
            core_abort <= 1'b0;
            found_key <= '0;
            found_core <= '0;
            keys_tried <= '0;
        end else begin
            state <= state_n;
            slot <= slot_n;
            key <= key_n;
            found <= found_n;
            failed <= failed_n;
            core_abort <= abort_n;
            found_key <= found_key_n;
            found_core <= found_core_n;
            keys_tried <= tried_n;
        end
    end
    assign busy = state == S_SEARCH;
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        // a slot whose key is already past the range is never pulsed
        assign core_rst[g] = slot[g] == C_RST && key[g] <= KEY_MAX;
        assign core_start[g] = slot[g] == C_START;
        assign core_key[g*KEY_WIDTH +: KEY_WIDTH] = key[g];
    end
endmodule

// File: tb/tb_rc4_key_search_scheduler.sv
// tb_rc4_key_search_scheduler: scoreboard bench with behavioural crack cores
module tb_rc4_key_search_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic go_a = 1'b0, go_b = 1'b0;
    logic [3:0] rst_a, start_a, done_a, hit_a, rst_b, start_b, done_b, hit_b;
    logic [95:0] key_a, key_b;
    logic abort_a, busy_a, found_a, failed_a, abort_b, busy_b, found_b, failed_b;
    logic [23:0] fkey_a, fkey_b;
    logic [1:0] fcore_a, fcore_b;
    logic [24:0] tried_a, tried_b;
    int passed = 0, total = 0;
    int lat_base = 4, lat_step = 1, hk0 = -1, hk1 = -1;
    int cnt_a [4];
    int cnt_b [4];
    logic [23:0] keyl_a [4];
    logic [23:0] qa [4][$];
    logic [3:0] prev_rst_a = '0;
    int pulses_a = 0;
    int starts_b [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    rc4_key_search_scheduler #(.NUM_CORES(4), .KEY_WIDTH(24), .KEY_MAX(24'd15)) dut_a (
        .clk(clk), .reset(reset), .go(go_a), .core_rst(rst_a), .core_start(start_a),
        .core_key(key_a), .core_done(done_a), .core_hit(hit_a), .core_abort(abort_a),
        .busy(busy_a), .found(found_a), .failed(failed_a), .found_key(fkey_a),
        .found_core(fcore_a), .keys_tried(tried_a));

    rc4_key_search_scheduler #(.NUM_CORES(4), .KEY_WIDTH(24), .KEY_MAX(24'd2)) dut_b (
        .clk(clk), .reset(reset), .go(go_b), .core_rst(rst_b), .core_start(start_b),
        .core_key(key_b), .core_done(done_b), .core_hit(hit_b), .core_abort(abort_b),
        .busy(busy_b), .found(found_b), .failed(failed_b), .found_key(fkey_b),
        .found_core(fcore_b), .keys_tried(tried_b));

    for (genvar g = 0; g < 4; g++) begin : g_hit
        assign hit_a[g] = done_a[g] && (int'(keyl_a[g]) == hk0 || int'(keyl_a[g]) == hk1);
        assign hit_b[g] = 1'b0;
    end

    // behavioural cores: done rises lat cycles after start, held until core_rst
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            done_a <= '0;
            done_b <= '0;
            for (int c = 0; c < 4; c++) begin
                cnt_a[c] <= 0;
                cnt_b[c] <= 0;
                keyl_a[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (rst_a[c]) begin
                    done_a[c] <= 1'b0;
                    cnt_a[c] <= 0;
                end else if (start_a[c]) begin
                    cnt_a[c] <= lat_base + c * lat_step;
                    keyl_a[c] <= key_a[c*24 +: 24];
                end else if (abort_a) cnt_a[c] <= 0;
                else if (cnt_a[c] == 1) begin
                    cnt_a[c] <= 0;
                    done_a[c] <= 1'b1;
                end else if (cnt_a[c] > 1) cnt_a[c] <= cnt_a[c] - 1;
                if (rst_b[c]) begin
                    done_b[c] <= 1'b0;
                    cnt_b[c] <= 0;
                end else if (start_b[c]) cnt_b[c] <= 3;
                else if (abort_b) cnt_b[c] <= 0;
                else if (cnt_b[c] == 1) begin
                    cnt_b[c] <= 0;
                    done_b[c] <= 1'b1;
                end else if (cnt_b[c] > 1) cnt_b[c] <= cnt_b[c] - 1;
            end
        end
    end

    // scoreboard: every start pops the expected next key of that core
    always @(negedge clk) begin
        logic [23:0] ev;
        for (int c = 0; c < 4; c++) begin
            pulses_a = pulses_a + int'(rst_a[c]) + int'(start_a[c]);
            if (start_a[c]) begin
                total++;
                if (qa[c].size() == 0)
                    $display("FAIL start_key core %0d: got start with key %0h, expected no start", c, key_a[c*24 +: 24]);
                else begin
                    ev = qa[c].pop_front();
                    if (key_a[c*24 +: 24] !== ev)
                        $display("FAIL start_key core %0d: got %0h expected %0h", c, key_a[c*24 +: 24], ev);
                    else passed++;
                end
                total++;
                if (prev_rst_a[c] !== 1'b1)
                    $display("FAIL rst_before_start core %0d: got prev rst %b expected 1", c, prev_rst_a[c]);
                else passed++;
            end
            prev_rst_a[c] = rst_a[c];
            if (start_b[c]) starts_b[c]++;
        end
    end

    task automatic load_queue(input int last);
        for (int c = 0; c < 4; c++) begin
            qa[c].delete();
            for (int k = c; k <= last; k += 4) qa[c].push_back(24'(k));
        end
    endtask

    task automatic pulse_go_a();
        @(negedge clk) go_a = 1'b1;
        @(negedge clk) go_a = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if ({rst_a, start_a} !== 8'h0) $display("FAIL reset_pulses: got %h expected 0", {rst_a, start_a}); else passed++;
        total++; if (key_a !== '0) $display("FAIL reset_key: got %h expected 0", key_a); else passed++;
        total++; if ({busy_a, found_a, failed_a, abort_a} !== 4'h0) $display("FAIL reset_flags: got %b expected 0000", {busy_a, found_a, failed_a, abort_a}); else passed++;
        total++; if (tried_a !== '0) $display("FAIL reset_tried: got %0d expected 0", tried_a); else passed++;
        total++; if ({fkey_a, fcore_a} !== '0) $display("FAIL reset_found_key: got %h expected 0", {fkey_a, fcore_a}); else passed++;
        total++; if ({busy_b, found_b, failed_b, abort_b, rst_b, start_b} !== '0) $display("FAIL reset_b: got %h expected 0", {busy_b, found_b, failed_b, abort_b, rst_b, start_b}); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_hit_single();
        int p0;
        lat_base = 4; lat_step = 1; hk0 = 6; hk1 = -1;
        load_queue(15);
        pulse_go_a();
        total++; if (busy_a !== 1'b1) $display("FAIL hit_busy: got %b expected 1", busy_a); else passed++;
        repeat (8) @(negedge clk);
        pulse_go_a();
        total++; if (busy_a !== 1'b1) $display("FAIL go_ignored_busy: got %b expected 1", busy_a); else passed++;
        for (int i = 0; i < 300 && !found_a && !failed_a; i++) @(negedge clk);
        total++; if (found_a !== 1'b1) $display("FAIL hit_found: got %b expected 1", found_a); else passed++;
        total++; if (fkey_a !== 24'd6) $display("FAIL hit_found_key: got %0d expected 6", fkey_a); else passed++;
        total++; if (fcore_a !== 2'd2) $display("FAIL hit_found_core: got %0d expected 2", fcore_a); else passed++;
        total++; if ({abort_a, busy_a, failed_a} !== 3'b100) $display("FAIL hit_abort_busy_failed: got %b expected 100", {abort_a, busy_a, failed_a}); else passed++;
        total++; if (tried_a !== 25'd7) $display("FAIL hit_tried: got %0d expected 7", tried_a); else passed++;
        p0 = pulses_a;
        repeat (20) @(negedge clk);
        total++; if (pulses_a - p0 !== 0) $display("FAIL hit_quiet: got %0d pulses expected 0", pulses_a - p0); else passed++;
    endtask

    task automatic test_go_in_found_no_hit();
        int p0;
        int left;
        hk0 = -1; hk1 = -1;
        load_queue(15);
        pulse_go_a();
        total++; if ({found_a, failed_a, abort_a, busy_a} !== 4'b0001) $display("FAIL restart_flags: got %b expected 0001", {found_a, failed_a, abort_a, busy_a}); else passed++;
        total++; if (tried_a !== '0) $display("FAIL restart_tried: got %0d expected 0", tried_a); else passed++;
        for (int i = 0; i < 400 && !found_a && !failed_a; i++) @(negedge clk);
        total++; if ({failed_a, found_a, abort_a, busy_a} !== 4'b1010) $display("FAIL nohit_flags: got %b expected 1010", {failed_a, found_a, abort_a, busy_a}); else passed++;
        total++; if (tried_a !== 25'd16) $display("FAIL nohit_tried: got %0d expected 16", tried_a); else passed++;
        left = 0;
        for (int c = 0; c < 4; c++) left += qa[c].size();
        total++; if (left !== 0) $display("FAIL nohit_keys_left: got %0d expected 0", left); else passed++;
        p0 = pulses_a;
        repeat (20) @(negedge clk);
        total++; if (pulses_a - p0 !== 0) $display("FAIL nohit_quiet: got %0d pulses expected 0", pulses_a - p0); else passed++;
    endtask

    task automatic test_simultaneous();
        lat_base = 5; lat_step = 0; hk0 = 1; hk1 = 3;
        load_queue(15);
        pulse_go_a();
        for (int i = 0; i < 200 && !found_a && !failed_a; i++) @(negedge clk);
        total++; if (found_a !== 1'b1) $display("FAIL simul_found: got %b expected 1", found_a); else passed++;
        total++; if (fcore_a !== 2'd1) $display("FAIL simul_found_core: got %0d expected 1", fcore_a); else passed++;
        total++; if (fkey_a !== 24'd1) $display("FAIL simul_found_key: got %0d expected 1", fkey_a); else passed++;
        total++; if (tried_a !== 25'd4) $display("FAIL simul_tried: got %0d expected 4", tried_a); else passed++;
    endtask

    task automatic test_small_keymax();
        @(negedge clk) go_b = 1'b1;
        @(negedge clk) go_b = 1'b0;
        for (int i = 0; i < 200 && !found_b && !failed_b; i++) @(negedge clk);
        total++; if ({failed_b, found_b, busy_b} !== 3'b100) $display("FAIL small_flags: got %b expected 100", {failed_b, found_b, busy_b}); else passed++;
        total++; if (tried_b !== 25'd3) $display("FAIL small_tried: got %0d expected 3", tried_b); else passed++;
        total++; if (starts_b[3] !== 0) $display("FAIL small_core3_starts: got %0d expected 0", starts_b[3]); else passed++;
        total++; if (starts_b[0] + starts_b[1] + starts_b[2] !== 3) $display("FAIL small_starts: got %0d expected 3", starts_b[0] + starts_b[1] + starts_b[2]); else passed++;
    endtask

    task automatic test_reset_mid();
        int p0;
        lat_base = 4; lat_step = 1; hk0 = -1; hk1 = -1;
        load_queue(15);
        pulse_go_a();
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if ({rst_a, start_a} !== 8'h0 || key_a !== '0) $display("FAIL midreset_core_outputs: got %h/%h expected 0", {rst_a, start_a}, key_a); else passed++;
        total++; if ({busy_a, found_a, failed_a, abort_a} !== 4'h0) $display("FAIL midreset_flags: got %b expected 0000", {busy_a, found_a, failed_a, abort_a}); else passed++;
        total++; if (tried_a !== '0) $display("FAIL midreset_tried: got %0d expected 0", tried_a); else passed++;
        p0 = pulses_a;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (busy_a !== 1'b0) $display("FAIL midreset_idle: got busy %b expected 0", busy_a); else passed++;
        total++; if (pulses_a - p0 !== 0) $display("FAIL midreset_quiet: got %0d pulses expected 0", pulses_a - p0); else passed++;
    endtask

    initial begin
        test_reset();
        test_hit_single();
        test_go_in_found_no_hit();
        test_simultaneous();
        test_small_keymax();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rc4_key_search_scheduler.md
Name: rc4_key_search_scheduler

Overview:
- Top-level sequencer for brute-force RC4 key search over NUM_CORES parallel crack cores; each core runs init, shuffle and decrypt for one key.
- Hands each core a key and pulses its reset and start.
- On each core_done, either issues that core's next key or records a hit and aborts all cores.
- Reports found or failed to the top level (LED/HEX driver).

Parameters:
NUM_CORES, 4, number of crack cores; core c tries keys c, c+NUM_CORES, c+2*NUM_CORES, ...
KEY_WIDTH, 24, key bus width.
KEY_MAX, 24'h3FFFFF, last key searched (inclusive).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high
go  input  1  start search; sampled only in S_IDLE, S_FOUND or S_FAILED
core_rst  output  NUM_CORES  per-core one-cycle reset pulse
core_start  output  NUM_CORES  per-core one-cycle start pulse
core_key  output  NUM_CORES*KEY_WIDTH  key for core c in bits [c*KEY_WIDTH +: KEY_WIDTH]
core_done  input  NUM_CORES  core finished current key (level, held until core_rst)
core_hit  input  NUM_CORES  valid with core_done: plaintext passed check
core_abort  output  1  broadcast stop to all cores (drives other_finished)
busy  output  1  search in progress
found  output  1  key found (sticky until next go)
failed  output  1  key space exhausted, no hit (sticky until next go)
found_key  output  KEY_WIDTH  winning key, valid when found=1
found_core  output  $clog2(NUM_CORES)  index of winning core
keys_tried  output  KEY_WIDTH+1  count of keys completed (hit or miss)

Behaviour:
- Reset: all outputs 0. Global FSM in S_IDLE; every core slot in C_IDLE; key registers 0.
- Global FSM (S_IDLE, S_SEARCH, S_FOUND, S_FAILED):
  - go=1 in S_IDLE, S_FOUND or S_FAILED -> S_SEARCH. Same edge: clear found, failed, core_abort, keys_tried; load slot c key = c; every slot -> C_RST.
  - go is ignored while in S_SEARCH.
  - S_SEARCH -> S_FOUND on the first cycle any slot reports a hit.
  - S_SEARCH -> S_FAILED when every slot is in C_EXH and none hit.
  - busy=1 exactly in S_SEARCH (registered).
- Per-core slot FSM (C_IDLE, C_RST, C_START, C_RUN, C_EXH):
  - C_RST: core_rst[c]=1 for one cycle; core_key[c] stable -> C_START.
  - C_START: core_start[c]=1 for one cycle -> C_RUN.
  - C_RUN: wait for core_done[c]; done and start are never high in the same cycle.
    - core_done[c]=1, core_hit[c]=0: keys_tried++. If key+NUM_CORES > KEY_MAX -> C_EXH. Else key += NUM_CORES, -> C_RST.
    - core_done[c]=1, core_hit[c]=1: keys_tried++; report hit.
  - Slot with initial key c > KEY_MAX goes directly from C_RST check to C_EXH (never started).
  - core_done while not in C_RUN is ignored.
- Key arithmetic: compute in KEY_WIDTH+1 bits so the compare never wraps.
- Hit handling:
  - Registered on the done edge: found=1, found_key = that slot's key, found_core=c, core_abort=1.
  - All slots -> C_IDLE; no further core_rst/core_start pulses.
  - Simultaneous hits in one cycle: lowest index wins; keys_tried adds all simultaneous completions.
  - core_abort stays 1 in S_FOUND and S_FAILED; cleared on next go.
- Latency:
  - go to first core_rst: 1 cycle.
  - core_rst to core_start: 1 cycle.
  - core_done (miss) to next core_rst: 1 cycle.
  - core_done (hit) to found/core_abort: 1 cycle.
- Reset mid-search: asynchronous return to reset state. Cores are not pulsed; the top level resets them with the same reset.

Test Plan (NUM_CORES=4, KEY_MAX=15, behavioural core model: done N cycles after start, hit for a chosen key):
- Pulse go, hit key 6 (core 2, second round) -> pulses in order rst/start for keys 0-3, then 4-7. found=1, found_key=6, found_core=2, core_abort=1, busy=0, keys_tried=7 (or as completed).
- No hit anywhere -> each core runs 4 keys. failed=1 after the last done, keys_tried=16, found=0, no pulses afterwards.
- Cores 1 and 3 hit in the same cycle (keys 1 and 3) -> found_core=1, found_key=1, keys_tried counts both.
- Pulse go again while busy -> ignored, key sequence unchanged. Pulse go in S_FOUND -> flags cleared, keys restart at 0-3.
- KEY_MAX=2 with NUM_CORES=4 -> core 3 never started (stays in C_EXH), failed=1 after cores 0-2 miss, keys_tried=3.
- Assert reset mid-search -> all outputs 0 next cycle, stays idle until go.
